// File: rtl/key_filter.sv
// Debounce, synchronise and edge-detect active-low push-buttons into level/press/release pulses.
// Optional auto-repeat pulses while held are compiled in when KEY_FILTER_REPEAT_EN is defined.
module key_filter #(
  parameter int N_KEYS           = 2,
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 30_000_000,
  parameter int REPEAT_RATE_CYC  = 7_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              any_press
);

  // state        | meaning
  // IDLE         | released and stable
  // PRESS_WAIT   | low seen, counting stable-low cycles
  // HELD         | press accepted, repeat timer running
  // RELEASE_WAIT | high seen, counting stable-high cycles, repeat timer frozen
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  if (DEBOUNCE_CYC < 2 || REPEAT_RATE_CYC < 1 || REPEAT_DELAY_CYC < 1) begin : g_bad_param
    $error("key_filter: DEBOUNCE_CYC must be >= 2 and repeat intervals >= 1");
  end

  state_t            state [N_KEYS];
  logic [CW-1:0]     cnt   [N_KEYS];
  logic [N_KEYS-1:0] sync1, sync2;
  logic [N_KEYS-1:0] level_q, press_q, release_q;

`ifdef KEY_FILTER_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int RPW = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [RPW-1:0] REP_FIRST_LAST = RPW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RPW-1:0] REP_NEXT_LAST  = RPW'(REPEAT_RATE_CYC - 1);

  logic [RPW-1:0]    rep_cnt [N_KEYS];
  logic [N_KEYS-1:0] rep_first;
  logic [N_KEYS-1:0] repeat_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        state[k] <= IDLE;
        cnt[k]   <= '0;
      end
`ifdef KEY_FILTER_REPEAT_EN
      repeat_q  <= '0;
      rep_first <= '0;
      for (int k = 0; k < N_KEYS; k++) rep_cnt[k] <= '0;
`endif
    end else begin
      press_q   <= '0;
      release_q <= '0;
`ifdef KEY_FILTER_REPEAT_EN
      repeat_q  <= '0;
`endif
      for (int k = 0; k < N_KEYS; k++) begin
        case (state[k])
          IDLE: begin
            if (!sync2[k]) begin
              state[k] <= PRESS_WAIT;
              cnt[k]   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (sync2[k]) begin
              state[k] <= IDLE;
            end else if (cnt[k] == CNT_LAST) begin
              state[k]   <= HELD;
              press_q[k] <= 1'b1;
              level_q[k] <= 1'b1;
`ifdef KEY_FILTER_REPEAT_EN
              rep_cnt[k]   <= '0;
              rep_first[k] <= 1'b1;
`endif
            end else begin
              cnt[k] <= cnt[k] + 1'b1;
            end
          end
          HELD: begin
            if (sync2[k]) begin
              state[k] <= RELEASE_WAIT;
              cnt[k]   <= '0;
            end
`ifdef KEY_FILTER_REPEAT_EN
            // Counter restarts after each pulse; the first interval uses the delay.
            else if (rep_cnt[k] == (rep_first[k] ? REP_FIRST_LAST : REP_NEXT_LAST)) begin
              repeat_q[k]  <= 1'b1;
              rep_cnt[k]   <= '0;
              rep_first[k] <= 1'b0;
            end else begin
              rep_cnt[k] <= rep_cnt[k] + 1'b1;
            end
`endif
          end
          RELEASE_WAIT: begin
            if (!sync2[k]) begin
              state[k] <= HELD;
            end else if (cnt[k] == CNT_LAST) begin
              state[k]     <= IDLE;
              release_q[k] <= 1'b1;
              level_q[k]   <= 1'b0;
            end else begin
              cnt[k] <= cnt[k] + 1'b1;
            end
          end
          default: state[k] <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      any_press   <= 1'b0;
    end else begin
      key_level   <= level_q;
      key_press   <= press_q;
      key_release <= release_q;
      any_press   <= |press_q;
    end
  end

`ifdef KEY_FILTER_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_repeat <= '0;
    else        key_repeat <= repeat_q;
  end
`else
  assign key_repeat = '0;
`endif

endmodule
